// File: rtl/studio2_portb_arbiter.sv
// Port B sequencer for the system dual-port RAM: the ioctl loader has priority
// over pixie video fetches, which are answered with a fixed-latency req/ack.
module studio2_portb_arbiter #(
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] CART_BASE = 16'h0400,
  parameter logic [15:0] VRAM_BASE = 16'h0900,
  parameter int          VRAM_SIZE = 256
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_active,
  input  logic [7:0]        dl_index,
  input  logic              dl_wr,
  input  logic [24:0]       dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              vid_req,
  input  logic [15:0]       vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_data,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic              dl_overrun,
  output logic              dl_range_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDW,
    S_ACK
  } state_t;

  localparam logic [16:0] LP_VRAM_LO = 17'(VRAM_BASE);
  localparam logic [16:0] LP_VRAM_HI = 17'(VRAM_BASE + VRAM_SIZE);

  state_t              r_state;
  logic                r_hv;
  logic [ADDR_W-1:0]   r_ha;
  logic [7:0]          r_hd;
  logic                r_vid_ack;
  logic [7:0]          r_vid_data;
  logic                r_ram_ce;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [7:0]          r_ram_din;
  logic                r_overrun;
  logic                r_range_err;
  logic                r_dl_active_q;

  logic [25:0]         w_map_addr;
  logic                w_map_oob;
  logic                w_wr_ok;
  logic                w_wr_oob;
  logic                w_dl_rise;
  logic                w_vid_in_win;
  logic                w_busy;
  logic                w_ovr_set;

  // Mapped address is kept wide so large image offsets can never alias into RAM.
  assign w_map_addr   = (dl_index == 8'd0) ? {1'b0, dl_addr}
                                           : ({1'b0, dl_addr} + {10'd0, CART_BASE});
  assign w_map_oob    = |w_map_addr[25:ADDR_W];
  assign w_wr_ok      = dl_wr & ~w_map_oob;
  assign w_wr_oob     = dl_wr & w_map_oob;
  assign w_dl_rise    = dl_active & ~r_dl_active_q;
  assign w_vid_in_win = ({1'b0, vid_addr} >= LP_VRAM_LO) && ({1'b0, vid_addr} < LP_VRAM_HI);
  assign w_busy       = (r_state != S_IDLE);
  assign w_ovr_set    = w_wr_ok & w_busy & r_hv;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_hv          <= 1'b0;
      r_ha          <= '0;
      r_hd          <= 8'h00;
      r_vid_ack     <= 1'b0;
      r_vid_data    <= 8'h00;
      r_ram_ce      <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_din     <= 8'h00;
      r_overrun     <= 1'b0;
      r_range_err   <= 1'b0;
      r_dl_active_q <= 1'b0;
    end else begin
      r_dl_active_q <= dl_active;
      r_range_err   <= (r_range_err & ~w_dl_rise) | w_wr_oob;
      r_overrun     <= (r_overrun & ~w_dl_rise) | w_ovr_set;

      if (w_wr_ok && w_busy && !r_hv) begin
        r_hv <= 1'b1;
        r_ha <= w_map_addr[ADDR_W-1:0];
        r_hd <= dl_data;
      end

      case (r_state)
        S_IDLE: begin
          if (r_hv) begin
            // The hold slot frees this cycle, so a strobe arriving now refills it.
            r_state    <= S_WR;
            r_ram_ce   <= 1'b1;
            r_ram_we   <= 1'b1;
            r_ram_addr <= r_ha;
            r_ram_din  <= r_hd;
            r_hv       <= w_wr_ok;
            if (w_wr_ok) begin
              r_ha <= w_map_addr[ADDR_W-1:0];
              r_hd <= dl_data;
            end
          end else if (w_wr_ok) begin
            r_state    <= S_WR;
            r_ram_ce   <= 1'b1;
            r_ram_we   <= 1'b1;
            r_ram_addr <= w_map_addr[ADDR_W-1:0];
            r_ram_din  <= dl_data;
          end else if (vid_req && (dl_active || !w_vid_in_win)) begin
            r_state    <= S_ACK;
            r_vid_ack  <= 1'b1;
            r_vid_data <= 8'h00;
          end else if (vid_req) begin
            r_state    <= S_RD;
            r_ram_ce   <= 1'b1;
            r_ram_we   <= 1'b0;
            r_ram_addr <= vid_addr[ADDR_W-1:0];
          end
        end
        S_WR: begin
          r_ram_ce <= 1'b0;
          r_ram_we <= 1'b0;
          r_state  <= S_IDLE;
        end
        S_RD: begin
          r_ram_ce <= 1'b0;
          r_state  <= S_RDW;
        end
        S_RDW: begin
          r_vid_data <= ram_dout;
          r_vid_ack  <= 1'b1;
          r_state    <= S_ACK;
        end
        S_ACK: begin
          r_vid_ack <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_ram_ce  <= 1'b0;
          r_ram_we  <= 1'b0;
          r_vid_ack <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign vid_ack      = r_vid_ack;
  assign vid_data     = r_vid_data;
  assign ram_ce       = r_ram_ce;
  assign ram_we       = r_ram_we;
  assign ram_addr     = r_ram_addr;
  assign ram_din      = r_ram_din;
  assign dl_overrun   = r_overrun;
  assign dl_range_err = r_range_err;

endmodule

// File: tb/tb_studio2_portb_arbiter.sv
// Directed bench for studio2_portb_arbiter with a registered RAM model on port B.
module tb_studio2_portb_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_active;
  logic [7:0]  dl_index;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_data;
  logic        ram_ce;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        dl_overrun;
  logic        dl_range_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:4095];

  studio2_portb_arbiter dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .dl_active    (dl_active),
    .dl_index     (dl_index),
    .dl_wr        (dl_wr),
    .dl_addr      (dl_addr),
    .dl_data      (dl_data),
    .vid_req      (vid_req),
    .vid_addr     (vid_addr),
    .vid_ack      (vid_ack),
    .vid_data     (vid_data),
    .ram_ce       (ram_ce),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .dl_overrun   (dl_overrun),
    .dl_range_err (dl_range_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Registered single-port RAM model: read data valid one cycle after ram_ce.
  always @(posedge clk_sys) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; dl_active = 1'b0; dl_index = 8'h00; dl_wr = 1'b0;
    dl_addr = '0; dl_data = 8'h00; vid_req = 1'b0; vid_addr = 16'h0000;
    step(); step();
    total++; if (ram_ce !== 1'b0) begin bad++; $display("FAIL reset_ram_ce got=%b exp=0", ram_ce); end
    total++; if (vid_ack !== 1'b0) begin bad++; $display("FAIL reset_vid_ack got=%b exp=0", vid_ack); end
    total++; if (vid_data !== 8'h00) begin bad++; $display("FAIL reset_vid_data got=%h exp=00", vid_data); end
    total++; if (ram_addr !== 12'h000) begin bad++; $display("FAIL reset_ram_addr got=%h exp=000", ram_addr); end
    total++; if ({dl_overrun, dl_range_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {dl_overrun, dl_range_err}); end
    reset = 1'b0;
    step();
    $display("test_reset: done");
  endtask

  task automatic test_write_sys();
    dl_active = 1'b1; step();
    dl_index = 8'd0; dl_addr = 25'h005; dl_data = 8'hA5; dl_wr = 1'b1;
    step(); dl_wr = 1'b0;
    total++; if ({ram_ce, ram_we} !== 2'b11) begin bad++; $display("FAIL sys_wr_strobe got=%b exp=11", {ram_ce, ram_we}); end
    total++; if (ram_addr !== 12'h005) begin bad++; $display("FAIL sys_wr_addr got=%h exp=005", ram_addr); end
    total++; if (ram_din !== 8'hA5) begin bad++; $display("FAIL sys_wr_data got=%h exp=a5", ram_din); end
    step();
    total++; if (ram_ce !== 1'b0) begin bad++; $display("FAIL sys_wr_one_cycle got=%b exp=0", ram_ce); end
    // Preload a display byte for the video tests.
    dl_addr = 25'h912; dl_data = 8'h3C; dl_wr = 1'b1;
    step(); dl_wr = 1'b0; step();
    $display("test_write_sys: addr=005 data=a5");
  endtask

  task automatic test_write_cart();
    dl_index = 8'd1; dl_addr = 25'h010; dl_data = 8'h5A; dl_wr = 1'b1;
    step(); dl_wr = 1'b0;
    total++; if ({ram_ce, ram_we, ram_addr} !== {2'b11, 12'h410}) begin bad++; $display("FAIL cart_wr_addr got=%b%b %h exp=11 410", ram_ce, ram_we, ram_addr); end
    step();
    dl_addr = 25'hC00; dl_data = 8'h77; dl_wr = 1'b1;
    step(); dl_wr = 1'b0;
    total++; if (ram_ce !== 1'b0) begin bad++; $display("FAIL cart_oob_no_ce got=%b exp=0", ram_ce); end
    total++; if (dl_range_err !== 1'b1) begin bad++; $display("FAIL cart_oob_flag got=%b exp=1", dl_range_err); end
    step(); step();
    total++; if (dl_range_err !== 1'b1) begin bad++; $display("FAIL cart_oob_sticky got=%b exp=1", dl_range_err); end
    total++; if (mem[0] === 8'h77) begin bad++; $display("FAIL cart_oob_alias got=%h exp=not 77", mem[0]); end
    dl_active = 1'b0; step();
    dl_active = 1'b1; step();
    total++; if (dl_range_err !== 1'b0) begin bad++; $display("FAIL cart_oob_clear got=%b exp=0", dl_range_err); end
    dl_active = 1'b0; dl_index = 8'd0; step();
    $display("test_write_cart: addr=410 then oob dropped");
  endtask

  task automatic test_video_read();
    vid_addr = 16'h0912; vid_req = 1'b1;
    step();
    total++; if ({ram_ce, ram_we, ram_addr} !== {2'b10, 12'h912}) begin bad++; $display("FAIL vid_rd_ce got=%b%b %h exp=10 912", ram_ce, ram_we, ram_addr); end
    step();
    total++; if (vid_ack !== 1'b0) begin bad++; $display("FAIL vid_rd_early_ack got=%b exp=0", vid_ack); end
    step();
    total++; if ({vid_ack, vid_data} !== {1'b1, 8'h3C}) begin bad++; $display("FAIL vid_rd_ack got=%b %h exp=1 3c", vid_ack, vid_data); end
    vid_req = 1'b0;
    step();
    total++; if (vid_ack !== 1'b0) begin bad++; $display("FAIL vid_rd_ack_pulse got=%b exp=0", vid_ack); end
    step();
    total++; if ({vid_ack, ram_ce} !== 2'b00) begin bad++; $display("FAIL vid_rd_no_second got=%b exp=00", {vid_ack, ram_ce}); end
    // Last byte of the window still goes to RAM.
    vid_addr = 16'h09FF; vid_req = 1'b1;
    step();
    total++; if (ram_ce !== 1'b1) begin bad++; $display("FAIL vid_win_top_ce got=%b exp=1", ram_ce); end
    step(); step();
    total++; if (vid_ack !== 1'b1) begin bad++; $display("FAIL vid_win_top_ack got=%b exp=1", vid_ack); end
    vid_req = 1'b0; step(); step();
    $display("test_video_read: 0912 -> 3c");
  endtask

  task automatic test_video_blank();
    vid_addr = 16'h0912; vid_req = 1'b1;
    step(); step(); step();
    vid_req = 1'b0; step(); step();
    vid_addr = 16'h0A00; vid_req = 1'b1;
    step();
    total++; if ({vid_ack, ram_ce, vid_data} !== {2'b10, 8'h00}) begin bad++; $display("FAIL blank_out_of_win got=%b%b %h exp=10 00", vid_ack, ram_ce, vid_data); end
    vid_req = 1'b0; step();
    vid_addr = 16'h08FF; vid_req = 1'b1;
    step();
    total++; if ({vid_ack, ram_ce} !== 2'b10) begin bad++; $display("FAIL blank_below_win got=%b exp=10", {vid_ack, ram_ce}); end
    vid_req = 1'b0; step();
    vid_addr = 16'h0912; vid_req = 1'b1;
    step(); step(); step();
    vid_req = 1'b0; step();
    dl_active = 1'b1; vid_req = 1'b1;
    step();
    total++; if ({vid_ack, ram_ce, vid_data} !== {2'b10, 8'h00}) begin bad++; $display("FAIL blank_dl_active got=%b%b %h exp=10 00", vid_ack, ram_ce, vid_data); end
    vid_req = 1'b0; dl_active = 1'b0; step(); step();
    $display("test_video_blank: 0a00, 08ff and loading give 00");
  endtask

  task automatic test_overrun();
    vid_addr = 16'h0912; vid_req = 1'b1;
    step();
    dl_index = 8'd0; dl_addr = 25'h100; dl_data = 8'h11; dl_wr = 1'b1;
    step();
    dl_addr = 25'h101; dl_data = 8'h22; dl_wr = 1'b1;
    step(); dl_wr = 1'b0;
    total++; if ({vid_ack, vid_data} !== {1'b1, 8'h3C}) begin bad++; $display("FAIL ovr_read_ack got=%b %h exp=1 3c", vid_ack, vid_data); end
    total++; if (dl_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", dl_overrun); end
    vid_req = 1'b0;
    step();
    total++; if (ram_ce !== 1'b0) begin bad++; $display("FAIL ovr_idle_gap got=%b exp=0", ram_ce); end
    step();
    total++; if ({ram_ce, ram_we, ram_addr, ram_din} !== {2'b11, 12'h100, 8'h11}) begin bad++; $display("FAIL ovr_held_write got=%b%b %h %h exp=11 100 11", ram_ce, ram_we, ram_addr, ram_din); end
    step(); step(); step();
    total++; if (mem[12'h100] !== 8'h11) begin bad++; $display("FAIL ovr_mem_first got=%h exp=11", mem[12'h100]); end
    total++; if (mem[12'h101] === 8'h22) begin bad++; $display("FAIL ovr_mem_second got=%h exp=not 22", mem[12'h101]); end
    total++; if (dl_overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", dl_overrun); end
    dl_active = 1'b1; step();
    total++; if (dl_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", dl_overrun); end
    dl_active = 1'b0; step();
    $display("test_overrun: 100<-11 kept, 101<-22 lost");
  endtask

  task automatic test_back_to_back();
    dl_addr = 25'h920; dl_data = 8'h66; dl_wr = 1'b1;
    vid_addr = 16'h0920; vid_req = 1'b1;
    step(); dl_wr = 1'b0;
    total++; if ({ram_ce, ram_we, ram_addr} !== {2'b11, 12'h920}) begin bad++; $display("FAIL b2b_write_first got=%b%b %h exp=11 920", ram_ce, ram_we, ram_addr); end
    step(); step(); step();
    total++; if (vid_ack !== 1'b0) begin bad++; $display("FAIL b2b_ack_t4 got=%b exp=0", vid_ack); end
    step();
    total++; if ({vid_ack, vid_data} !== {1'b1, 8'h66}) begin bad++; $display("FAIL b2b_ack_t5 got=%b %h exp=1 66", vid_ack, vid_data); end
    vid_req = 1'b0; step(); step();
    $display("test_back_to_back: write 920 then read 66");
  endtask

  task automatic test_reset_mid();
    vid_addr = 16'h0912; vid_req = 1'b1;
    step(); step();
    reset = 1'b1;
    #1;
    total++; if ({ram_ce, ram_we, vid_ack} !== 3'b000) begin bad++; $display("FAIL rst_mid_strobes got=%b exp=000", {ram_ce, ram_we, vid_ack}); end
    total++; if ({vid_data, ram_addr} !== {8'h00, 12'h000}) begin bad++; $display("FAIL rst_mid_data got=%h %h exp=00 000", vid_data, ram_addr); end
    step(); step();
    total++; if (vid_ack !== 1'b0) begin bad++; $display("FAIL rst_mid_no_ack got=%b exp=0", vid_ack); end
    reset = 1'b0;
    step();
    total++; if (ram_ce !== 1'b1) begin bad++; $display("FAIL rst_rel_ce got=%b exp=1", ram_ce); end
    step();
    step();
    total++; if ({vid_ack, vid_data} !== {1'b1, 8'h3C}) begin bad++; $display("FAIL rst_rel_ack got=%b %h exp=1 3c", vid_ack, vid_data); end
    vid_req = 1'b0; step();
    $display("test_reset_mid: aborted read restarted");
  endtask

  initial begin
    test_reset();
    test_write_sys();
    test_write_cart();
    test_video_read();
    test_video_blank();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
